// File: rtl/dcache_if.sv
// dcache_if: bundles the CPU-side request/response signals and the off-chip
// line-memory signals of the L1 data-cache controller.
//   slave  - controller view: takes CPU requests and memory responses, drives
//            load data, stall and memory requests.
//   master - environment view (pipeline + memory): the opposite directions.
// Signal names keep the controller-relative _i/_o suffixes so that both views
// read the same as the controller's port list.
interface dcache_if #(
  parameter int unsigned LINE_W = 256
);
  logic              cpu_req_i;
  logic              cpu_write_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic [31:0]       cpu_data_o;
  logic              cpu_stall_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache
// for the MEM stage. Hits complete with no extra cycle; misses stall the
// pipeline while the victim line is written back (if dirty) and the missing
// line is fetched.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset
//   bus   - dcache_if.slave: CPU request/response and off-chip line memory
module dcache_controller #(
  parameter int unsigned LINES      = 32,
  parameter int unsigned LINE_BYTES = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  dcache_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = OFF_W - 2;
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e            r_state;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tags  [LINES];
  logic [LINE_W-1:0] r_lines [LINES];
  logic [TAG_W-1:0]  r_req_tag;
  logic [IDX_W-1:0]  r_req_idx;
  logic              r_mem_enable;
  logic              r_mem_write;
  logic [31:0]       r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_wsel;
  logic [LINE_W-1:0] w_line;
  logic              w_hit;
  logic              w_read_hit;
  logic              w_ack;
  logic              w_unused_addr;

  assign w_tag         = bus.cpu_addr_i[31 -: TAG_W];
  assign w_idx         = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign w_wsel        = bus.cpu_addr_i[2 +: WSEL_W];
  assign w_unused_addr = ^bus.cpu_addr_i[1:0];
  assign w_line        = r_lines[w_idx];

  assign w_hit      = bus.cpu_req_i & r_valid[w_idx] & (r_tags[w_idx] == w_tag);
  assign w_read_hit = (r_state == StIdle) & w_hit & ~bus.cpu_write_i;
  // An ack coinciding with the enable pulse predates the request; ignore it.
  assign w_ack      = bus.mem_ack_i & ~r_mem_enable;

  assign bus.cpu_data_o   = w_read_hit ? w_line[{w_wsel, 5'd0} +: 32] : 32'd0;
  assign bus.cpu_stall_o  = (r_state != StIdle) | (bus.cpu_req_i & ~w_hit);
  assign bus.mem_enable_o = r_mem_enable;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Tag/data arrays keep their contents; clearing valid makes them dead.
      r_state      <= StIdle;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_req_tag    <= '0;
      r_req_idx    <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      r_mem_enable <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.cpu_req_i) begin
            if (w_hit) begin
              if (bus.cpu_write_i) begin
                r_lines[w_idx][{w_wsel, 5'd0} +: 32] <= bus.cpu_data_i;
                r_dirty[w_idx]                      <= 1'b1;
              end
            end else begin
              r_req_tag    <= w_tag;
              r_req_idx    <= w_idx;
              r_mem_enable <= 1'b1;
              if (r_valid[w_idx] && r_dirty[w_idx]) begin
                r_state     <= StWriteback;
                r_mem_write <= 1'b1;
                r_mem_addr  <= {r_tags[w_idx], w_idx, {OFF_W{1'b0}}};
                r_mem_data  <= r_lines[w_idx];
              end else begin
                r_state     <= StAllocate;
                r_mem_write <= 1'b0;
                r_mem_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
                r_mem_data  <= '0;
              end
            end
          end
        end
        StWriteback: begin
          // Fetch pulse goes out in the first ALLOCATE cycle, after the ack.
          if (w_ack) begin
            r_state      <= StAllocate;
            r_mem_enable <= 1'b1;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= {r_req_tag, r_req_idx, {OFF_W{1'b0}}};
            r_mem_data   <= '0;
          end
        end
        StAllocate: begin
          if (w_ack) begin
            r_lines[r_req_idx] <= bus.mem_data_i;
            r_tags[r_req_idx]  <= r_req_tag;
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b0;
            r_state            <= StIdle;
            r_mem_addr         <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
  localparam int MEM_LAT = 10;
  localparam int TMO     = 200;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus ();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: expectations pushed when stimulus is driven, observations
  // pushed by the memory monitor, compared when the access retires.
  mem_ev_t     exp_ev_q[$];
  mem_ev_t     seen_q[$];
  int          seen_rd = 0;
  logic [31:0] exp_data_q[$];
  int          exp_stall_q[$];

  int           enable_cycles = 0;
  logic [255:0] mem_model [logic [31:0]];
  logic         auto_ack  = 1'b0;
  logic         man_ack   = 1'b0;
  logic [255:0] auto_data = '0;

  assign bus.mem_ack_i  = auto_ack | man_ack;
  assign bus.mem_data_i = auto_data;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 | (a + 32'(4 * i));
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [255:0] l, input int i);
    return l[i*32 +: 32];
  endfunction

  // Off-chip memory: records every request, acks MEM_LAT cycles after enable.
  initial begin : memory
    int           cnt;
    mem_ev_t      cur;
    logic [255:0] l;
    cnt = -1;
    cur = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'(i + 1) * 32'h11;
    mem_model[32'h0000_0100] = l;
    forever begin
      @(negedge clk);
      auto_ack = 1'b0;
      if (bus.mem_enable_o) begin
        enable_cycles++;
        cur.wr   = bus.mem_write_o;
        cur.addr = bus.mem_addr_o;
        cur.data = bus.mem_data_o;
        seen_q.push_back(cur);
        cnt = MEM_LAT;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          auto_ack = 1'b1;
          if (cur.wr) mem_model[cur.addr] = cur.data;
          else auto_data = line_of(cur.addr);
          cnt = -1;
        end
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_access(input int stalls, input logic [31:0] data);
    exp_stall_q.push_back(stalls);
    exp_data_q.push_back(data);
  endtask

  task automatic expect_mem(input logic wr, input logic [31:0] a, input logic [255:0] d);
    mem_ev_t e;
    e.wr   = wr;
    e.addr = a;
    e.data = d;
    exp_ev_q.push_back(e);
  endtask

  task automatic check_mem(input string tag);
    int      n_seen;
    mem_ev_t e;
    mem_ev_t s;
    n_seen = seen_q.size() - seen_rd;
    check({tag, "_mem_count"}, n_seen, exp_ev_q.size());
    while (exp_ev_q.size() > 0) begin
      e = exp_ev_q.pop_front();
      if (seen_rd < seen_q.size()) begin
        s = seen_q[seen_rd];
        seen_rd++;
        check({tag, "_mem_write"}, s.wr, e.wr);
        check({tag, "_mem_addr"}, s.addr, e.addr);
        if (e.wr) check({tag, "_mem_data"}, s.data, e.data);
      end
    end
    seen_rd = seen_q.size();
  endtask

  // Called just after a rising edge; returns just after the retiring edge.
  task automatic do_access(input string tag, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
    int          st;
    logic [31:0] rd;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = a;
    bus.cpu_data_i  = d;
    st = 0;
    @(negedge clk);
    while (bus.cpu_stall_o && st < TMO) begin
      st++;
      @(negedge clk);
    end
    rd = bus.cpu_data_o;
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    check({tag, "_stall"}, st, exp_stall_q.pop_front());
    if (!wr) check({tag, "_data"}, rd, exp_data_q.pop_front());
    else void'(exp_data_q.pop_front());
    check_mem(tag);
  endtask

  initial begin : stimulus
    int           en0;
    int           st;
    logic [255:0] exp_wb;

    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_data_i  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", bus.cpu_stall_o, 0);
    check("rst_enable", bus.mem_enable_o, 0);
    check("rst_write", bus.mem_write_o, 0);
    check("rst_addr", bus.mem_addr_o, 0);
    check("rst_mdata", bus.mem_data_o, 0);
    check("rst_cdata", bus.cpu_data_o, 0);
    @(posedge clk);
    #1;

    // Clean miss.
    en0 = enable_cycles;
    expect_mem(1'b0, 32'h0000_0100, '0);
    expect_access(12, 32'h22);
    do_access("ld104_miss", 1'b0, 32'h0000_0104, '0);
    check("ld104_enables", enable_cycles - en0, 1);

    // Hits.
    en0 = enable_cycles;
    expect_access(0, 32'h22);
    do_access("ld104_hit", 1'b0, 32'h0000_0104, '0);
    expect_access(0, 32'h88);
    do_access("ld11c_hit", 1'b0, 32'h0000_011C, '0);
    expect_access(0, '0);
    do_access("st108", 1'b1, 32'h0000_0108, 32'hDEAD_BEEF);
    expect_access(0, 32'hDEAD_BEEF);
    do_access("ld108", 1'b0, 32'h0000_0108, '0);
    check("hits_enables", enable_cycles - en0, 0);

    // Dirty miss: write-back then fetch.
    exp_wb = line_of(32'h0000_0100);
    exp_wb[64 +: 32] = 32'hDEAD_BEEF;
    expect_mem(1'b1, 32'h0000_0100, exp_wb);
    expect_mem(1'b0, 32'h0000_0500, '0);
    expect_access(23, word_of(line_of(32'h0000_0500), 2));
    do_access("ld508_dirty", 1'b0, 32'h0000_0508, '0);
    check("wb_landed", line_of(32'h0000_0100), exp_wb);

    // Address wiggles while a miss is outstanding.
    expect_mem(1'b0, 32'h0000_1500, '0);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h0000_1508;
    @(negedge clk);
    check("mm_detect_stall", bus.cpu_stall_o, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.cpu_addr_i = 32'h0000_0F00;
    @(negedge clk);
    check("mm_addr_latched", bus.mem_addr_o, 32'h0000_1500);
    check("mm_write", bus.mem_write_o, 0);
    @(posedge clk);
    #1 bus.cpu_addr_i = 32'h0000_1508;
    st = 0;
    @(negedge clk);
    while (bus.cpu_stall_o && st < TMO) begin
      st++;
      @(negedge clk);
    end
    check("mm_stall_rest", st, 9);
    check("mm_data", bus.cpu_data_o, word_of(line_of(32'h0000_1500), 2));
    @(posedge clk);
    #1 bus.cpu_req_i = 1'b0;
    check_mem("mm");

    // Stray ack while idle.
    en0 = enable_cycles;
    man_ack = 1'b1;
    @(negedge clk);
    check("stray_stall", bus.cpu_stall_o, 0);
    @(posedge clk);
    #1 man_ack = 1'b0;
    expect_access(0, word_of(line_of(32'h0000_1500), 2));
    do_access("ld1508_after_stray", 1'b0, 32'h0000_1508, '0);
    check("stray_enables", enable_cycles - en0, 0);

    // Dirty the line, then reset in the 4th ALLOCATE cycle of another miss.
    expect_access(0, '0);
    do_access("st1508", 1'b1, 32'h0000_1508, 32'hCAFE_F00D);
    expect_mem(1'b0, 32'h0000_2000, '0);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h0000_2000;
    @(negedge clk);
    check("rmid_detect_stall", bus.cpu_stall_o, 1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_mem("rmid");
    en0 = enable_cycles;
    @(negedge clk);
    check("rmid_stall", bus.cpu_stall_o, 0);
    check("rmid_addr", bus.mem_addr_o, 0);
    repeat (10) @(negedge clk);
    check("rmid_late_ack_stall", bus.cpu_stall_o, 0);
    check("rmid_enables", enable_cycles - en0, 0);
    @(posedge clk);
    #1;
    expect_mem(1'b0, 32'h0000_2000, '0);
    expect_access(12, word_of(line_of(32'h0000_2000), 0));
    do_access("ld2000_again", 1'b0, 32'h0000_2000, '0);
    // The dirty store was discarded: clean refetch, original data.
    expect_mem(1'b0, 32'h0000_1500, '0);
    expect_access(12, word_of(line_of(32'h0000_1500), 2));
    do_access("ld1508_after_rst", 1'b0, 32'h0000_1508, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

L1 data-cache controller for the MEM stage of the 5-stage pipeline. It consumes the MemRead/MemWrite, ALU result (address) and RS_Data2 (store data) outputs of the EX/MEM register. It serves loads and stores from a direct-mapped, write-back, write-allocate cache and handles misses against the off-chip data memory. While a miss is serviced it raises `cpu_stall_o`, which freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- `LINES`, 32: number of cache lines; index width `IDX_W` = log2(LINES) = 5.
- `LINE_BYTES`, 32: bytes per line; line = 256 bits = 8 words; offset width 5.
- `TAG_W`, 22: 32 − `IDX_W` − 5.

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cpu_req_i`  in  1  access request (EX/MEM MemRead | MemWrite).
- `cpu_write_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address (EX/MEM ALU result); bits [1:0] ignored.
- `cpu_data_i`  in  32  store data (EX/MEM RS_Data2).
- `cpu_data_o`  out  32  load data; valid in the same cycle as a read hit.
- `cpu_stall_o`  out  1  pipeline stall.
- `mem_enable_o`  out  1  one-cycle request pulse to off-chip memory.
- `mem_write_o`  out  1  1 = line write-back, 0 = line fetch.
- `mem_addr_o`  out  32  line-aligned address; bits [4:0] = 0.
- `mem_data_o`  out  256  write-back line data.
- `mem_data_i`  in  256  fetched line data; valid when `mem_ack_i`=1.
- `mem_ack_i`  in  1  one-cycle completion from memory.

## Operation
- Address split: tag = [31:10], index = [9:5], word select = [4:2].
- Per-line state: valid, dirty, tag, 256-bit data.
- Hit = `cpu_req_i` & valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, read hit:
  - `cpu_data_o` = selected word of the line, combinationally.
  - `cpu_stall_o` = 0.
- IDLE, write hit:
  - Selected word is replaced by `cpu_data_i` at the next edge.
  - dirty[index] is set at the same edge.
  - No stall.
- IDLE, miss: `cpu_stall_o` = 1 in the same cycle. Latch request tag and index. Victim valid & dirty → WRITEBACK, else → ALLOCATE.
- WRITEBACK:
  - On entry, `mem_enable_o`=1 for exactly one cycle.
  - For the whole state: `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`=victim line.
  - On `mem_ack_i` → ALLOCATE.
- ALLOCATE:
  - On entry, `mem_enable_o`=1 for exactly one cycle.
  - For the whole state: `mem_write_o`=0, `mem_addr_o`={latched tag, index, 5'b0}.
  - On `mem_ack_i`: line ← `mem_data_i`, tag ← latched tag, valid=1, dirty=0; → IDLE.
- After returning to IDLE, the request is re-evaluated as a normal hit. A store merges its word and sets dirty at that point.
- `cpu_stall_o` = (state != IDLE) | (`cpu_req_i` & ~hit).
- `cpu_data_o` = 0 whenever there is no read hit.
- Upstream holds `cpu_*` inputs stable while stalled. Changes to `cpu_*` during WRITEBACK/ALLOCATE are ignored; memory addressing uses the latched values.
- `mem_ack_i` in IDLE, or before the enable pulse, is ignored.

## Timing
- Reset, in the cycle after `rst_i`=1 sampled:
  - State = IDLE.
  - All valid and dirty bits = 0.
  - `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - `cpu_stall_o` follows its equation (0 with no request).
  - Tag/data arrays need no reset.
- Reset mid-miss: abandon the transaction. Enable stays 0 and dirty data is discarded. Any late ack is ignored.
- Hit latency: 0 extra cycles.
- Clean miss: stall cycles = 1 (detect) + N (cycles from enable to ack) + 1 (IDLE re-check hit).
- Dirty miss: adds 1 + N for the write-back.
- WRITEBACK→ALLOCATE: the fetch enable pulse is issued in the first ALLOCATE cycle, never in the same cycle as the write-back ack.
- `cpu_req_i`=0: no state change, no stall, no array update.

## Test plan
- Reset, then load 0x0000_0104 with memory line 0x100 = words 0..7 = 0x11..0x88, ack latency 10 → stall for 12 cycles. Single enable pulse, `mem_addr_o`=0x0000_0100, `mem_write_o`=0. Then `cpu_data_o`=0x22 with stall low.
- Repeat load 0x104, then 0x11C → both return in 0 cycles (0x22, 0x88), no enable.
- Store 0xDEADBEEF to 0x108 (hit) → no stall. Dirty set; a following load of 0x108 returns 0xDEADBEEF.
- Load 0x0000_0508 (same index 8, different tag) → WRITEBACK first:
  - `mem_addr_o`=0x100, `mem_write_o`=1, word 2 of `mem_data_o`=0xDEADBEEF.
  - Then ALLOCATE at 0x500; stall = 2 + 2×10 + 1 = 23 cycles.
- Assert `rst_i` in the 4th ALLOCATE cycle, then deliver ack → no array update, state IDLE. The next access to the same address misses again.
- Change `cpu_addr_i` mid-miss → `mem_addr_o` keeps the latched value.
- Ack with no pending request → ignored.
